wm_phase_timer: RTL

- Timing and watchdog stage that sits directly upstream of the washing-machine sequencing FSM.
- Observes the FSM's actuator outputs (motor_on, drain_on, fill_on) and its rinse flag (water_wash).
- Counts prescaled ticks for the active phase and returns the completion events the FSM consumes: timeout (wash/rinse done) and spin_timeout (spin done).
- Also supervises the fill valve: flags a sticky fault if filling exceeds its limit.

---
 rtl/wm_pkg.sv | 39 +++
 rtl/wm_tick_prescaler.sv | 48 ++++
 rtl/wm_phase_timer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer.
// Contents:
//   WM_STATE_W   width of the wash-controller state code (controller and timer agree)
//   phase_e      timer phase encoding
//   req_e        request class decoded from the actuator outputs
//   *_DEF        default tick counts per phase
//   multi_hot3   true when two or more of three actuator enables are high
package wm_pkg;

  localparam int WM_STATE_W = 3;

  typedef enum logic [WM_STATE_W-1:0] {
    PH_IDLE    = 3'd0,
    PH_WASH    = 3'd1,
    PH_RINSE   = 3'd2,
    PH_SPIN    = 3'd3,
    PH_FILL    = 3'd4,
    PH_EXPIRED = 3'd5
  } phase_e;

  // Request class; WASH and RINSE share one class because water_wash is
  // only looked at when the motor request first appears.
  typedef enum logic [1:0] {
    RQ_NONE  = 2'd0,
    RQ_MOTOR = 2'd1,
    RQ_DRAIN = 2'd2,
    RQ_FILL  = 2'd3
  } req_e;

  localparam int WASH_TICKS_DEF  = 30;
  localparam int RINSE_TICKS_DEF = 20;
  localparam int SPIN_TICKS_DEF  = 15;
  localparam int FILL_LIMIT_DEF  = 60;

  function automatic logic multi_hot3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Tick prescaler: divides clk by CLK_DIV and emits a one-cycle tick on the
// cycle where the count wraps.
// Ports:
//   clk, reset  clock, async active-low reset
//   clear       force count to 0 (takes priority over en/hold)
//   en          counting allowed this cycle
//   hold        freeze the count
//   tick        high for the cycle in which the count wraps CLK_DIV-1 -> 0
module wm_tick_prescaler #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !hold) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer and fill watchdog in front of the washing-machine sequencer.
// Watches the sequencer's actuator outputs, times the active phase in
// prescaled ticks and reports completion events back to it.
// Ports:
//   clk, reset     clock, async active-low reset
//   motor_on       wash/rinse agitation request
//   water_wash     1 = rinse, 0 = soap wash; looked at on phase entry only
//   drain_on       spin request
//   fill_on        fill valve open
//   hold           freeze prescaler and tick counter
//   timeout        wash/rinse elapsed (held while motor_on stays high)
//   spin_timeout   spin elapsed (held while drain_on stays high)
//   fill_fault     fill ran past FILL_LIMIT; sticky until reset
//   seq_err        two or more actuator requests seen together; sticky
//   elapsed        ticks elapsed in the current phase, saturates at the limit
//
// state   | meaning
// IDLE    | no request, counters cleared
// WASH    | motor_on, soap pass, counting toward WASH_TICKS
// RINSE   | motor_on, rinse pass, counting toward RINSE_TICKS
// SPIN    | drain_on, counting toward SPIN_TICKS
// FILL    | fill_on, counting toward FILL_LIMIT
// EXPIRED | limit reached, waiting for the originating request to change
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int CLK_DIV     = 1000,
  parameter int WASH_TICKS  = WASH_TICKS_DEF,
  parameter int RINSE_TICKS = RINSE_TICKS_DEF,
  parameter int SPIN_TICKS  = SPIN_TICKS_DEF,
  parameter int FILL_LIMIT  = FILL_LIMIT_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_on,
  input  logic             water_wash,
  input  logic             drain_on,
  input  logic             fill_on,
  input  logic             hold,
  output logic             timeout,
  output logic             spin_timeout,
  output logic             fill_fault,
  output logic             seq_err,
  output logic [CNT_W-1:0] elapsed
);

  phase_e           phase_q, phase_d;
  req_e             grp_q, grp_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             timeout_q, timeout_d;
  logic             spin_timeout_q, spin_timeout_d;
  logic             fill_fault_q, fill_fault_d;
  logic             seq_err_q, seq_err_d;

  req_e             req_grp;
  phase_e           req_ph;
  logic [CNT_W-1:0] req_limit;
  logic             entry;
  logic             active;
  logic             tick;
  logic [CNT_W-1:0] elapsed_inc;

  always_comb begin
    req_grp   = RQ_NONE;
    req_ph    = PH_IDLE;
    req_limit = '0;
    if (motor_on) begin
      req_grp   = RQ_MOTOR;
      req_ph    = water_wash ? PH_RINSE : PH_WASH;
      req_limit = water_wash ? CNT_W'(RINSE_TICKS) : CNT_W'(WASH_TICKS);
    end else if (drain_on) begin
      req_grp   = RQ_DRAIN;
      req_ph    = PH_SPIN;
      req_limit = CNT_W'(SPIN_TICKS);
    end else if (fill_on) begin
      req_grp   = RQ_FILL;
      req_ph    = PH_FILL;
      req_limit = CNT_W'(FILL_LIMIT);
    end
  end

  // Comparing request classes (not phases) keeps EXPIRED parked while its
  // request holds, and ignores water_wash toggling mid-phase.
  assign entry  = (req_grp != grp_q);
  assign active = (phase_q == PH_WASH) || (phase_q == PH_RINSE) ||
                  (phase_q == PH_SPIN) || (phase_q == PH_FILL);
  assign elapsed_inc = elapsed_q + CNT_W'(1);

  wm_tick_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(entry),
    .en   (active),
    .hold (hold),
    .tick (tick)
  );

  always_comb begin
    phase_d        = phase_q;
    grp_d          = grp_q;
    elapsed_d      = elapsed_q;
    limit_d        = limit_q;
    timeout_d      = timeout_q;
    spin_timeout_d = spin_timeout_q;
    fill_fault_d   = fill_fault_q;
    seq_err_d      = seq_err_q | multi_hot3(motor_on, drain_on, fill_on);

    if (entry) begin
      // A changed request discards the old count without reporting it.
      phase_d        = req_ph;
      grp_d          = req_grp;
      elapsed_d      = '0;
      limit_d        = req_limit;
      timeout_d      = 1'b0;
      spin_timeout_d = 1'b0;
    end else if (active && tick) begin
      elapsed_d = elapsed_inc;
      if (elapsed_inc == limit_q) begin
        phase_d = PH_EXPIRED;
        case (phase_q)
          PH_WASH, PH_RINSE: timeout_d      = 1'b1;
          PH_SPIN:           spin_timeout_d = 1'b1;
          PH_FILL:           fill_fault_d   = 1'b1;
          default:           ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q        <= PH_IDLE;
      grp_q          <= RQ_NONE;
      elapsed_q      <= '0;
      limit_q        <= '0;
      timeout_q      <= 1'b0;
      spin_timeout_q <= 1'b0;
      fill_fault_q   <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      grp_q          <= grp_d;
      elapsed_q      <= elapsed_d;
      limit_q        <= limit_d;
      timeout_q      <= timeout_d;
      spin_timeout_q <= spin_timeout_d;
      fill_fault_q   <= fill_fault_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign timeout      = timeout_q;
  assign spin_timeout = spin_timeout_q;
  assign fill_fault   = fill_fault_q;
  assign seq_err      = seq_err_q;
  assign elapsed      = elapsed_q;

endmodule
